// File: rtl/frame_reader.sv
// frame_reader
//   Walks a WIDTH x HEIGHT frame in raster order, issues pipelined Avalon-MM
//   reads for each pixel, and streams the returned words out with their (x,y)
//   coordinates on a valid/ready interface.
//   Pixel (x,y) lives at ((STRIDE*y + x) * pixel_size + offset) mod 2^32.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   start                 one-cycle frame request (ignored while busy)
//   offset, pixel_size    frame base byte address / bytes per pixel
//   busy, done            frame in progress / one-cycle completion pulse
//   avm_*                 Avalon-MM read master (pipelined, in-order responses)
//   pix_data/x/y/valid    pixel stream out, pix_ready from the consumer
module frame_reader #(
  parameter int PIXELBITS  = 6,
  parameter int STRIDE     = 641,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          offset,
  input  logic [PIXELBITS-1:0] pixel_size,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          avm_address,
  output logic                 avm_read,
  input  logic                 avm_waitrequest,
  input  logic [31:0]          avm_readdata,
  input  logic                 avm_readdatavalid,
  output logic [31:0]          pix_data,
  output logic [9:0]           pix_x,
  output logic [9:0]           pix_y,
  output logic                 pix_valid,
  input  logic                 pix_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [9:0]    X_LAST  = 10'(WIDTH - 1);
  localparam logic [9:0]    Y_LAST  = 10'(HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t        state;
  logic [31:0]   psize_q;
  logic [31:0]   stride_bytes;
  logic [31:0]   row_base;
  logic [31:0]   next_row;
  logic [9:0]    rx, ry, ox, oy;
  logic [CW-1:0] inflight, inflight_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] wptr, rptr;
  logic [31:0]   mem [FIFO_DEPTH];

  logic accept, pop, push, last_req, last_pix;

  assign accept   = avm_read & ~avm_waitrequest;
  assign pop      = pix_valid & pix_ready;
  assign push     = avm_readdatavalid & (state != S_IDLE);
  assign last_req = (rx == X_LAST) && (ry == Y_LAST);
  assign last_pix = (ox == X_LAST) && (oy == Y_LAST);
  assign next_row = row_base + stride_bytes;

  assign pix_valid = (count != '0);
  assign pix_data  = mem[rptr];
  assign pix_x     = ox;
  assign pix_y     = oy;

  // inflight counts every accepted read not yet handed to the consumer,
  // i.e. outstanding responses plus buffered words; it gates new requests.
  always_comb begin
    inflight_nxt = inflight;
    if (accept && !pop)
      inflight_nxt = inflight + CW'(1);
    else if (!accept && pop)
      inflight_nxt = inflight - CW'(1);
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (!push && pop)
      count_nxt = count - CW'(1);
  end

  // ---- request stage: FSM, address generation, credit-gated avm_read ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      avm_read     <= 1'b0;
      avm_address  <= '0;
      psize_q      <= '0;
      stride_bytes <= '0;
      row_base     <= '0;
      rx           <= '0;
      ry           <= '0;
      ox           <= '0;
      oy           <= '0;
      inflight     <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= inflight_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_ISSUE;
            busy         <= 1'b1;
            avm_read     <= 1'b1;
            avm_address  <= offset;
            row_base     <= offset;
            psize_q      <= 32'(pixel_size);
            stride_bytes <= 32'(STRIDE) * 32'(pixel_size);
            rx           <= '0;
            ry           <= '0;
            ox           <= '0;
            oy           <= '0;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            // Incremental address: step by pixel_size within a row, by the
            // row pitch in bytes at each row wrap.
            if (rx == X_LAST) begin
              rx          <= '0;
              ry          <= ry + 10'd1;
              row_base    <= next_row;
              avm_address <= next_row;
            end else begin
              rx          <= rx + 10'd1;
              avm_address <= avm_address + psize_q;
            end
            if (last_req) begin
              state    <= S_DRAIN;
              avm_read <= 1'b0;
            end else begin
              avm_read <= (inflight_nxt < DEPTH_C);
            end
          end else if (!avm_read) begin
            // A stalled request stays asserted; only an idle request line
            // re-evaluates credits.
            avm_read <= (inflight_nxt < DEPTH_C);
          end
        end
        S_DRAIN: begin
        end
        default: state <= S_IDLE;
      endcase

      // ---- output stage: coordinate counters and frame completion ----
      if (pop) begin
        if (ox == X_LAST) begin
          ox <= '0;
          oy <= oy + 10'd1;
        end else begin
          ox <= ox + 10'd1;
        end
        if (last_pix) begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  // ---- response stage: in-order response buffer ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= avm_readdata;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader
//   Table-driven bench for frame_reader configured as a 4x2 frame with a row
//   pitch of 5 pixels. Each table row is one frame: base offset, pixel size,
//   the hand-computed address list, and optional waitrequest stall, consumer
//   backpressure, start-while-busy pulse and back-to-back start. A small
//   Avalon slave model answers with a fixed 2-cycle latency. A mid-frame
//   reset sequence is written out by hand.
module tb_frame_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] offset;
  logic [5:0]  pixel_size;
  logic        busy, done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] pix_data;
  logic [9:0]  pix_x, pix_y;
  logic        pix_valid;
  logic        pix_ready;

  int checks   = 0;
  int failures = 0;

  frame_reader #(
    .PIXELBITS(6), .STRIDE(5), .WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(rst), .start(start), .offset(offset),
    .pixel_size(pixel_size), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .pix_ready(pix_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC3C3_5A5A;
  endfunction

  // Avalon slave: 2-cycle read latency, optional stall of a chosen request.
  int          cur_wait_at;
  int          cur_wait_len;
  int          m_acc;
  int          wcnt;
  logic        s1_v;
  logic [31:0] s1_d;

  always @(posedge clk) begin
    if (rst) begin
      s1_v              <= 1'b0;
      s1_d              <= '0;
      avm_readdatavalid <= 1'b0;
      avm_readdata      <= '0;
      avm_waitrequest   <= 1'b0;
      wcnt              <= 0;
      m_acc             <= 0;
    end else begin
      s1_v              <= avm_read && !avm_waitrequest;
      s1_d              <= mdata(avm_address);
      avm_readdatavalid <= s1_v;
      avm_readdata      <= s1_d;
      if (start && !busy) m_acc <= 0;
      if (avm_read && !avm_waitrequest) begin
        m_acc <= m_acc + 1;
        if (m_acc + 1 == cur_wait_at && cur_wait_len > 0) begin
          avm_waitrequest <= 1'b1;
          wcnt            <= cur_wait_len;
        end
      end else if (avm_waitrequest) begin
        if (wcnt == 1) avm_waitrequest <= 1'b0;
        else           wcnt <= wcnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: condition not reached, expected it within budget", name);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_avm_read"},  32'(avm_read),  32'd0);
    chk({tag, "_avm_addr"},  avm_address,    32'd0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_data"},  pix_data,       32'd0);
    chk({tag, "_pix_x"},     32'(pix_x),     32'd0);
    chk({tag, "_pix_y"},     32'(pix_y),     32'd0);
  endtask

  typedef struct {
    logic [31:0]         offset;
    logic [5:0]          psize;
    logic [0:7][31:0]    addr;
    int                  wait_at;
    int                  wait_len;
    int                  roff_at;
    int                  roff_len;
    int                  busy_start_at;
    bit                  b2b;
  } vec_t;

  vec_t vecs[6];

  task automatic run_frame(input int v);
    int          cyc, n_acc, n_pix, n_done, last_hs, n_stall, pix_at_roff;
    bit          fin, viol, prev_stall, prev_hold;
    logic [31:0] prev_addr, prev_d;
    logic [9:0]  prev_x, prev_y;
    string       t;
    t = $sformatf("f%0d", v);
    cyc = 0; n_acc = 0; n_pix = 0; n_done = 0; last_hs = -10; n_stall = 0;
    pix_at_roff = 0; fin = 0; viol = 0; prev_stall = 0; prev_hold = 0;
    prev_addr = '0; prev_d = '0; prev_x = '0; prev_y = '0;
    cur_wait_at  = vecs[v].wait_at;
    cur_wait_len = vecs[v].wait_len;
    if (!vecs[v].b2b) repeat (2) @(negedge clk);
    offset     = vecs[v].offset;
    pixel_size = vecs[v].psize;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({t, "_busy_after_start"}, 32'(busy),     32'd1);
    chk({t, "_read_after_start"}, 32'(avm_read), 32'd1);
    cyc = 1;
    while (!fin && cyc < 200) begin
      pix_ready = !(cyc >= vecs[v].roff_at && cyc < vecs[v].roff_at + vecs[v].roff_len);
      if (cyc == vecs[v].busy_start_at) begin
        start      = 1'b1;
        offset     = 32'hDEAD_0000;
        pixel_size = 6'd7;
      end else begin
        start = 1'b0;
      end
      if (prev_stall) begin
        chk({t, "_stall_read"}, 32'(avm_read), 32'd1);
        chk({t, "_stall_addr"}, avm_address,   prev_addr);
      end
      if (prev_hold) begin
        chk({t, "_hold_valid"}, 32'(pix_valid), 32'd1);
        chk({t, "_hold_data"},  pix_data,       prev_d);
        chk({t, "_hold_x"},     32'(pix_x),     32'(prev_x));
        chk({t, "_hold_y"},     32'(pix_y),     32'(prev_y));
      end
      if (avm_read && (n_acc - n_pix) >= 8) viol = 1;
      if (avm_read && avm_waitrequest) n_stall++;
      if (cyc == vecs[v].roff_at) pix_at_roff = n_pix;
      if (vecs[v].roff_len > 0 && cyc == vecs[v].roff_at + vecs[v].roff_len - 1) begin
        chk({t, "_bp_read_low"},   32'(avm_read), 32'd0);
        chk({t, "_bp_all_issued"}, 32'(n_acc),    32'd8);
        chk({t, "_bp_no_output"},  32'(n_pix),    32'(pix_at_roff));
      end
      if (avm_read && !avm_waitrequest) begin
        if (n_acc < 8) chk($sformatf("%s_addr%0d", t, n_acc), avm_address, vecs[v].addr[n_acc]);
        else           fail({t, "_extra_request"});
        n_acc++;
      end
      if (pix_valid && pix_ready) begin
        if (n_pix < 8) begin
          chk($sformatf("%s_data%0d", t, n_pix), pix_data,   mdata(vecs[v].addr[n_pix]));
          chk($sformatf("%s_x%0d", t, n_pix),    32'(pix_x), 32'(n_pix % 4));
          chk($sformatf("%s_y%0d", t, n_pix),    32'(pix_y), 32'(n_pix / 4));
        end else begin
          fail({t, "_extra_pixel"});
        end
        n_pix++;
        last_hs = cyc;
      end
      if (done) begin
        n_done++;
        chk({t, "_done_pix_count"}, 32'(n_pix),   32'd8);
        chk({t, "_done_timing"},    32'(last_hs), 32'(cyc - 1));
        chk({t, "_done_busy_low"},  32'(busy),    32'd0);
        fin = 1;
      end
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      prev_hold  = pix_valid && !pix_ready;
      prev_d     = pix_data;
      prev_x     = pix_x;
      prev_y     = pix_y;
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!fin) fail({t, "_done_timeout"});
    chk({t, "_requests"},    32'(n_acc),  32'd8);
    chk({t, "_pixels"},      32'(n_pix),  32'd8);
    chk({t, "_done_pulses"}, 32'(n_done), 32'd1);
    chk({t, "_credit_ok"},   32'(viol),   32'd0);
    chk({t, "_stall_cycles"}, 32'(n_stall), 32'(vecs[v].wait_len));
  endtask

  initial begin
    int  hs;
    bit  saw_done, saw_busy;

    vecs[0] = '{32'h0000_1000, 6'd4,
                {32'h1000, 32'h1004, 32'h1008, 32'h100C,
                 32'h1014, 32'h1018, 32'h101C, 32'h1020},
                -1, 0, -1, 0, -1, 1'b0};
    vecs[1] = '{32'h0000_1000, 6'd4,
                {32'h1000, 32'h1004, 32'h1008, 32'h100C,
                 32'h1014, 32'h1018, 32'h101C, 32'h1020},
                1, 3, -1, 0, -1, 1'b0};
    vecs[2] = '{32'h0000_0200, 6'd2,
                {32'h200, 32'h202, 32'h204, 32'h206,
                 32'h20A, 32'h20C, 32'h20E, 32'h210},
                -1, 0, 2, 20, -1, 1'b0};
    vecs[3] = '{32'hFFFF_FFF8, 6'd4,
                {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004,
                 32'h0000_000C, 32'h0000_0010, 32'h0000_0014, 32'h0000_0018},
                -1, 0, -1, 0, 5, 1'b0};
    vecs[4] = '{32'h0000_0000, 6'd1,
                {32'h0, 32'h1, 32'h2, 32'h3,
                 32'h5, 32'h6, 32'h7, 32'h8},
                -1, 0, -1, 0, -1, 1'b1};
    vecs[5] = '{32'h8000_0000, 6'd63,
                {32'h8000_0000, 32'h8000_003F, 32'h8000_007E, 32'h8000_00BD,
                 32'h8000_013B, 32'h8000_017A, 32'h8000_01B9, 32'h8000_01F8},
                -1, 0, -1, 0, -1, 1'b0};

    rst = 1'b1; start = 1'b0; offset = '0; pixel_size = '0; pix_ready = 1'b1;
    cur_wait_at = -1; cur_wait_len = 0;
    repeat (3) @(negedge clk);
    chk_reset_outs("por");
    rst = 1'b0;

    for (int v = 0; v < 6; v++) run_frame(v);

    // Mid-frame reset after three pixels have been handed over.
    cur_wait_at = -1; cur_wait_len = 0;
    repeat (2) @(negedge clk);
    offset = 32'h0000_1000; pixel_size = 6'd4; pix_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 100 && hs < 3; c++) begin
      if (pix_valid && pix_ready) hs++;
      if (hs < 3) @(negedge clk);
    end
    if (hs < 3) fail("mid_reset_three_pixels");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid_reset");
    rst = 1'b0;
    saw_done = 0; saw_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (busy) saw_busy = 1;
    end
    chk("mid_reset_no_done", 32'(saw_done), 32'd0);
    chk("mid_reset_idle",    32'(saw_busy), 32'd0);
    run_frame(0);

    saw_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("final_no_extra_done", 32'(saw_done), 32'd0);
    chk("final_busy_low",      32'(busy),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
# frame_reader

Read-side counterpart of the Julia worker's pixel write path. Walks a frame in raster order, computes each pixel's SDRAM address with the same layout rule the worker uses when writing, issues pipelined Avalon-MM reads and streams the returned pixels out with their coordinates on a valid/ready interface. Sits between the SDRAM controller and the display or readback consumer.

## Interface

- PIXELBITS, 6: width of `pixel_size`
- STRIDE, 641: row pitch in pixels (address layout rule)
- WIDTH, 640: pixels per row read (x = 0..WIDTH-1)
- HEIGHT, 480: rows read (y = 0..HEIGHT-1)
- FIFO_DEPTH, 8: response buffer entries; power of two, at least 2
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to read a frame; ignored while busy
- offset  in  32  frame base byte address, sampled on accepted start
- pixel_size  in  PIXELBITS  bytes per pixel, sampled on accepted start
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last pixel handshake
- avm_address  out  32  read byte address
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  response data
- avm_readdatavalid  in  1  response valid; responses return in request order
- pix_data  out  32  pixel word
- pix_x  out  10  pixel column
- pix_y  out  10  pixel row
- pix_valid  out  1  output valid
- pix_ready  in  1  consumer ready

## Operation

- Address of pixel (x,y) = ((STRIDE*y + x) * pixel_size + offset) mod 2^32, using unsigned arithmetic with full-width intermediates. An incremental implementation is allowed if it produces identical values.
- States:
  - IDLE: busy=0, avm_read=0. On start=1, latch offset and pixel_size, clear the request counters (rx,ry) and output counters (ox,oy), then go to ISSUE.
  - ISSUE: avm_read=1 whenever credits are available, with the address of (rx,ry). A request is accepted on avm_read & !avm_waitrequest. On acceptance, rx increments; at WIDTH-1 it wraps to 0 and ry increments. Acceptance of pixel (WIDTH-1,HEIGHT-1) moves the FSM to DRAIN.
  - DRAIN: no new requests. Stays until the last output handshake, then pulses done and returns to IDLE.
- Credits:
  - outstanding = accepted reads whose data has not yet returned. buffered = FIFO occupancy.
  - avm_read may assert only while outstanding + buffered < FIFO_DEPTH, so the FIFO never overflows.
  - Once avm_read asserts, it stays high with a stable address until accepted, even if credits change.
- Every avm_readdatavalid writes avm_readdata into the FIFO. pix_data is the FIFO head.
- pix_x and pix_y come from the (ox,oy) counters, which advance on pix_valid & pix_ready with the same wrap rule as (rx,ry).
- avm_readdatavalid is ignored in IDLE.
- start while busy is ignored; no queuing.
- Reset values: busy=0, done=0, avm_read=0, avm_address=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0. FIFO and all counters are cleared.
- Reset mid-frame abandons the frame and does not pulse done. The interconnect is reset together with this block.

## Timing

- An accepted start on cycle N gives busy=1 and the first avm_read=1 on cycle N+1.
- Maximum request throughput: 1 per cycle while credits are available and waitrequest=0.
- readdatavalid on cycle M gives pix_valid on cycle M+1 at the earliest (registered FIFO).
- FIFO write and read in the same cycle are both performed. Occupancy is unchanged when the FIFO is full or non-empty.
- Once pix_valid is high, it stays high with stable pix_data, pix_x and pix_y until the handshake.
- The last output handshake on cycle K gives done=1 and busy=0 on cycle K+1.
- A new start is accepted on cycle K+1 at the earliest.

## Test plan

- Basic frame:
  - Setup: WIDTH=4, HEIGHT=2, STRIDE=5, pixel_size=4, offset=0x1000, waitrequest=0, fixed 2-cycle read latency, pix_ready=1.
  - Required: addresses 0x1000, 0x1004, 0x1008, 0x100C, 0x1014, 0x1018, 0x101C, 0x1020.
  - Required: 8 pixels out in order with (x,y) from (0,0) to (3,1), then a single done pulse.
- Waitrequest: hold waitrequest=1 for 3 cycles on the second request -> avm_read and address 0x1004 stay stable, exactly one acceptance, no duplicate or skipped address.
- Backpressure:
  - Stimulus: pix_ready=0 for 20 cycles.
  - Required: outstanding + buffered never exceeds FIFO_DEPTH (8). avm_read drops to 0.
  - Required: after pix_ready returns, the data sequence is unchanged.
- Address wrap: offset=0xFFFFFFF8, pixel_size=4 -> third address is 0x00000000, fourth is 0x00000004.
- Start handling:
  - start pulsed while busy -> ignored, frame unaffected.
  - start on the cycle after done -> second frame begins with address equal to the new offset.
- Mid-frame reset: reset after 3 pixels accepted -> next cycle all outputs are at their reset values, no done pulse. A following start completes a full correct frame.
